rx_stream_xor: RTL and testbench

//  Parametrised receive-side descrambler: XORs an AXI-Stream payload with a
//  32-bit LFSR keystream, N=DATA_WIDTH/32 lanes per beat. Full backpressure via a
//  2-entry skid buffer; SOF/EOF pass through; optional keystream reseed on SOF.

---
 rtl/rx_stream_xor.sv | 213 +++++++++++++++++++++
 tb/tb_rx_stream_xor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_stream_xor.sv
// Receive-side AXI-Stream descrambler: payload XOR 32-bit LFSR keystream, N lanes per beat,
// 2-entry skid buffer. Define RX_STREAM_XOR_STATS_EN to add frame/beat counters and SOF error flag.
module rx_stream_xor #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_INIT  = 32'h0000_0001
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  i_cfg_enable,
  input  logic [31:0]           i_cfg_seed,
  input  logic                  i_cfg_reload,
  input  logic                  i_cfg_sof_reseed,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_sof,
  input  logic                  s_axis_eof,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_sof,
  output logic                  m_axis_eof
`ifdef RX_STREAM_XOR_STATS_EN
  ,
  input  logic                  i_stats_clr,
  output logic [31:0]           o_frame_cnt,
  output logic [31:0]           o_beat_cnt,
  output logic                  o_sof_err
`endif
);

  localparam int LANES = DATA_WIDTH / 32;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] lfsr_advance(input logic [31:0] s0);
    logic [31:0] s;
    s = s0;
    for (int k = 0; k < LANES; k++) begin
      s = lfsr_step(s);
    end
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_keystream(input logic [31:0] s0);
    logic [31:0]           s;
    logic [DATA_WIDTH-1:0] ks;
    s  = s0;
    ks = '0;
    for (int k = 0; k < LANES; k++) begin
      ks[32*k +: 32] = s;
      s = lfsr_step(s);
    end
    return ks;
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    if (s == 32'h0000_0000) begin
      return 32'h0000_0001;
    end else begin
      return s;
    end
  endfunction

  logic                  tready_r;
  logic [31:0]           lfsr_r;
  logic                  out_valid_r, out_sof_r, out_eof_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  skid_valid_r, skid_sof_r, skid_eof_r;
  logic [DATA_WIDTH-1:0] skid_data_r;

  logic                  accept_s, drain_s, reload_now_s;
  logic [31:0]           seed_fixed_s, lane0_state_s, lfsr_next_s;
  logic [DATA_WIDTH-1:0] beat_data_s;
  logic                  out_valid_next_s, out_sof_next_s, out_eof_next_s;
  logic [DATA_WIDTH-1:0] out_data_next_s;
  logic                  skid_valid_next_s, skid_sof_next_s, skid_eof_next_s;
  logic [DATA_WIDTH-1:0] skid_data_next_s;

  assign accept_s      = s_axis_tvalid & tready_r;
  assign drain_s       = out_valid_r & m_axis_tready;
  assign seed_fixed_s  = seed_fix(i_cfg_seed);
  assign reload_now_s  = i_cfg_reload | (i_cfg_sof_reseed & accept_s & s_axis_sof);
  assign lane0_state_s = reload_now_s ? seed_fixed_s : lfsr_r;
  assign beat_data_s   = s_axis_tdata ^ make_keystream(lane0_state_s);

  // Keystream state: advances only on accepted beats; a reload without accept just loads the seed.
  always_comb begin
    lfsr_next_s = lfsr_r;
    if (accept_s) begin
      lfsr_next_s = lfsr_advance(lane0_state_s);
    end else if (i_cfg_reload) begin
      lfsr_next_s = seed_fixed_s;
    end else begin
      lfsr_next_s = lfsr_r;
    end
  end

  // Skid buffer next state: the output register is always filled before the skid register.
  always_comb begin
    out_valid_next_s  = out_valid_r;
    out_data_next_s   = out_data_r;
    out_sof_next_s    = out_sof_r;
    out_eof_next_s    = out_eof_r;
    skid_valid_next_s = skid_valid_r;
    skid_data_next_s  = skid_data_r;
    skid_sof_next_s   = skid_sof_r;
    skid_eof_next_s   = skid_eof_r;
    if (drain_s) begin
      if (skid_valid_r) begin
        out_data_next_s   = skid_data_r;
        out_sof_next_s    = skid_sof_r;
        out_eof_next_s    = skid_eof_r;
        skid_valid_next_s = 1'b0;
      end else if (accept_s) begin
        out_data_next_s   = beat_data_s;
        out_sof_next_s    = s_axis_sof;
        out_eof_next_s    = s_axis_eof;
      end else begin
        out_valid_next_s  = 1'b0;
      end
    end else if (accept_s) begin
      if (out_valid_r) begin
        skid_valid_next_s = 1'b1;
        skid_data_next_s  = beat_data_s;
        skid_sof_next_s   = s_axis_sof;
        skid_eof_next_s   = s_axis_eof;
      end else begin
        out_valid_next_s  = 1'b1;
        out_data_next_s   = beat_data_s;
        out_sof_next_s    = s_axis_sof;
        out_eof_next_s    = s_axis_eof;
      end
    end else begin
      out_valid_next_s = out_valid_r;
    end
  end

  // State registers; tready_r equals (enable delayed one cycle) & (skid empty).
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tready_r     <= 1'b0;
      lfsr_r       <= LFSR_INIT;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_sof_r    <= 1'b0;
      out_eof_r    <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_sof_r   <= 1'b0;
      skid_eof_r   <= 1'b0;
    end else begin
      tready_r     <= i_cfg_enable & ~skid_valid_next_s;
      lfsr_r       <= lfsr_next_s;
      out_valid_r  <= out_valid_next_s;
      out_data_r   <= out_data_next_s;
      out_sof_r    <= out_sof_next_s;
      out_eof_r    <= out_eof_next_s;
      skid_valid_r <= skid_valid_next_s;
      skid_data_r  <= skid_data_next_s;
      skid_sof_r   <= skid_sof_next_s;
      skid_eof_r   <= skid_eof_next_s;
    end
  end

  assign s_axis_tready = tready_r;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_sof    = out_sof_r;
  assign m_axis_eof    = out_eof_r;

`ifdef RX_STREAM_XOR_STATS_EN
  logic        in_frame_r;
  logic        sof_err_r;
  logic [31:0] frame_cnt_r, beat_cnt_r;
  logic        framing_bad_s;

  assign framing_bad_s = accept_s & (s_axis_sof ? in_frame_r : ~in_frame_r);

  // Frame statistics; clear has priority over a same-cycle increment.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      in_frame_r  <= 1'b0;
      sof_err_r   <= 1'b0;
      frame_cnt_r <= 32'h0000_0000;
      beat_cnt_r  <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        in_frame_r <= s_axis_sof ? ~s_axis_eof : (in_frame_r & ~s_axis_eof);
      end else begin
        in_frame_r <= in_frame_r;
      end
      if (i_stats_clr) begin
        sof_err_r   <= 1'b0;
        frame_cnt_r <= 32'h0000_0000;
        beat_cnt_r  <= 32'h0000_0000;
      end else begin
        sof_err_r   <= sof_err_r | framing_bad_s;
        frame_cnt_r <= frame_cnt_r + {31'h0, accept_s & s_axis_eof};
        beat_cnt_r  <= beat_cnt_r + {31'h0, accept_s};
      end
    end
  end

  assign o_frame_cnt = frame_cnt_r;
  assign o_beat_cnt  = beat_cnt_r;
  assign o_sof_err   = sof_err_r;
`endif

endmodule

// File: tb/tb_rx_stream_xor.sv
// Scoreboard bench for rx_stream_xor: a reference model pushes expected beats on accept,
// a monitor pops and compares on every output transfer.
module tb_rx_stream_xor;
  localparam int          DW    = 64;
  localparam int          N     = DW / 32;
  localparam logic [31:0] LINIT = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_enable = 1'b0, cfg_reload = 1'b0, cfg_sof_reseed = 1'b0;
  logic [31:0]   cfg_seed = 32'h0;
  logic          s_tvalid = 1'b0, s_tready, s_sof = 1'b0, s_eof = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid, m_tready = 1'b1, m_sof, m_eof;
  logic [DW-1:0] m_tdata;
`ifdef RX_STREAM_XOR_STATS_EN
  logic          stats_clr = 1'b0;
  logic [31:0]   frame_cnt, beat_cnt;
  logic          sof_err;
`endif

  always #5 clk = ~clk;

  rx_stream_xor #(.DATA_WIDTH(DW), .LFSR_INIT(LINIT)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .i_cfg_enable(cfg_enable), .i_cfg_seed(cfg_seed), .i_cfg_reload(cfg_reload),
    .i_cfg_sof_reseed(cfg_sof_reseed),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_sof(s_sof), .s_axis_eof(s_eof),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_sof(m_sof), .m_axis_eof(m_eof)
`ifdef RX_STREAM_XOR_STATS_EN
    , .i_stats_clr(stats_clr), .o_frame_cnt(frame_cnt), .o_beat_cnt(beat_cnt), .o_sof_err(sof_err)
`endif
  );

  int            n_checks = 0, n_fail = 0;
  int            acc_cnt = 0;
  int            m_mode = 0;
  logic [DW+1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference keystream: Galois-free shift register defined by taps 31,21,1,0.
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] fb;
    fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'h1;
    return (s << 1) | fb;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: observes the cycle just before each edge and predicts accepted beats.
  logic [31:0]   mdl_lfsr = LINIT;
  logic [31:0]   mdl_st;
  logic [DW-1:0] mdl_exp;
  logic          mdl_acc;
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_lfsr = LINIT;
    end else begin
      mdl_acc = s_tvalid & s_tready;
      if (cfg_reload || (cfg_sof_reseed && mdl_acc && s_sof))
        mdl_st = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
      else
        mdl_st = mdl_lfsr;
      if (mdl_acc) begin
        for (int k = 0; k < N; k++) begin
          mdl_exp[32*k +: 32] = s_tdata[32*k +: 32] ^ mdl_st;
          mdl_st = ref_next(mdl_st);
        end
        exp_q.push_back({mdl_exp, s_sof, s_eof});
        acc_cnt++;
      end
      mdl_lfsr = (mdl_acc || cfg_reload) ? mdl_st : mdl_lfsr;
    end
  end

  // Monitor: compares transfers against the queue and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW+1:0] held;
  logic [DW+1:0] exp_beat;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {127'h0, m_tvalid}, 128'h1);
        check("stall_hold", {m_tdata, m_sof, m_eof}, held);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_tdata, m_sof, m_eof}, 128'h0);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", {m_tdata, m_sof, m_eof}, exp_beat);
        end
      end
      prev_stall = m_tvalid & ~m_tready;
      held = {m_tdata, m_sof, m_eof};
    end
  end

  always @(posedge clk) begin
    #1;
    case (m_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'b0;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (called at posedge+1) and return at posedge+1 after it is accepted.
  task automatic send(input logic [DW-1:0] d, input logic sof, input logic eof, input logic rl);
    int t;
    t = 0;
    s_tvalid = 1'b1; s_tdata = d; s_sof = sof; s_eof = eof; cfg_reload = rl;
    @(negedge clk);
    while (!s_tready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: tready got 0 required 1");
    end
    tick();
    s_tvalid = 1'b0; cfg_reload = 1'b0;
  endtask

  logic burst_done = 1'b0;
  int   acc0;
  int   t;
  logic in_frame;

  initial begin
    #2;
    check("rst_tready", {127'h0, s_tready}, 128'h0);
    check("rst_tvalid", {127'h0, m_tvalid}, 128'h0);
    check("rst_tdata", {m_tdata, m_sof, m_eof}, 128'h0);
    tick();
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    cfg_seed = 32'h1;
    cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    tick();
    check("enable_tready", {127'h0, s_tready}, 128'h1);

    // Basic frame from seed 1 with latency check on the first beat
    send('0, 1'b1, 1'b0, 1'b0);
    check("latency1", {127'h0, m_tvalid}, 128'h1);
    send('0, 1'b0, 1'b0, 1'b0);
    send('0, 1'b0, 1'b1, 1'b0);
    tick();

    // Reload pulse coincident with an accepted beat, including the zero-seed case
    cfg_seed = 32'hDEAD_BEEF;
    send('0, 1'b1, 1'b1, 1'b1);
    cfg_seed = 32'h0;
    send('0, 1'b1, 1'b1, 1'b1);
    tick();

    // SOF reseed: two 3-beat frames restart the keystream
    cfg_seed = 32'h1;
    cfg_sof_reseed = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send('0, 1'b1, 1'b0, 1'b0);
      send('0, 1'b0, 1'b0, 1'b0);
      send('0, 1'b0, 1'b1, 1'b0);
    end
    cfg_sof_reseed = 1'b0;
    tick();

    // Backpressure during an 8-beat burst
    acc0 = acc_cnt;
    m_mode = 1; m_tready = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) send(rnd_data(), 1'(b == 0), 1'(b == 7), 1'b0);
        burst_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    check("bp_accepts", 128'(acc_cnt - acc0), 128'd2);
    check("bp_tready", {127'h0, s_tready}, 128'h0);
    tick();
    m_mode = 0; m_tready = 1'b1;
    t = 0;
    while (!burst_done && t < 200) begin t++; tick(); end
    check("bp_done", {127'h0, burst_done}, 128'h1);

    // Enable dropped mid-frame: tready low from the 2nd cycle, keystream resumes
    send(rnd_data(), 1'b1, 1'b0, 1'b0);
    cfg_enable = 1'b0;
    s_tvalid = 1'b1; s_tdata = rnd_data(); s_sof = 1'b0; s_eof = 1'b0;
    @(negedge clk);
    check("dis_cycle1", {127'h0, s_tready}, 128'h1);
    @(negedge clk);
    check("dis_cycle2", {127'h0, s_tready}, 128'h0);
    tick();
    s_tvalid = 1'b0;
    repeat (3) tick();
    cfg_enable = 1'b1;
    send(rnd_data(), 1'b0, 1'b1, 1'b0);

    // Randomized traffic with random backpressure, reloads and gaps
    m_mode = 2;
    in_frame = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic sof, eof;
      sof = ~in_frame;
      eof = ($urandom_range(0, 3) == 0);
      if (sof) cfg_sof_reseed = 1'($urandom_range(0, 1));
      cfg_seed = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      send(rnd_data(), sof, eof, 1'($urandom_range(0, 19) == 0));
      in_frame = ~eof;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    cfg_sof_reseed = 1'b0;
    m_mode = 0; m_tready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin t++; tick(); end
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    // Reset with the skid register full
    m_mode = 1; m_tready = 1'b0;
    acc0 = acc_cnt;
    s_tvalid = 1'b1; s_tdata = rnd_data(); s_sof = 1'b1; s_eof = 1'b0;
    repeat (4) @(negedge clk);
    check("skid_full_accepts", 128'(acc_cnt - acc0), 128'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tvalid", {127'h0, m_tvalid}, 128'h0);
    check("rstmid_tready", {127'h0, s_tready}, 128'h0);
    s_tvalid = 1'b0;
    exp_q.delete();
    m_mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    // First beat after reset must use LFSR_INIT
    send('0, 1'b1, 1'b1, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin t++; tick(); end
    check("final_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1);
  end

endmodule
